// File: rtl/id_ex_issue_if.sv
// id_ex_issue_if: decode-side request, EX/MEM forwarding sources, pipeline
// control and the registered execute-side response of the ID/EX issue register.
//   master : driver of decode/forwarding/control, consumer of outputs
//   slave  : the issue register itself
interface id_ex_issue_if #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
);
  // decode request
  logic                id_valid_i;
  logic [ALUOP_W-1:0]  id_aluop_i;
  logic [ALUSEL_W-1:0] id_alusel_i;
  logic                id_re1_i, id_re2_i;
  logic [RADDR_W-1:0]  id_raddr1_i, id_raddr2_i;
  logic                id_use_imm_i;
  logic [DATA_W-1:0]   id_imm_i;
  logic [RADDR_W-1:0]  id_wd_i;
  logic                id_wreg_i;
  logic [DATA_W-1:0]   rf_rdata1_i, rf_rdata2_i;
  // forwarding sources
  logic [RADDR_W-1:0]  ex_wd_i, mem_wd_i;
  logic                ex_wreg_i, mem_wreg_i, ex_load_i;
  logic [DATA_W-1:0]   ex_wdata_i, mem_wdata_i;
  // pipeline control
  logic                stall_i, flush_i;
  // response
  logic                id_ready_o;
  logic                valid_o;
  logic [ALUOP_W-1:0]  aluop_o;
  logic [ALUSEL_W-1:0] alusel_o;
  logic [DATA_W-1:0]   reg1_o, reg2_o;
  logic [RADDR_W-1:0]  wd_o;
  logic                wreg_o;
  logic [15:0]         hazard_cnt_o;

  modport master (
    output id_valid_i, id_aluop_i, id_alusel_i, id_re1_i, id_re2_i,
           id_raddr1_i, id_raddr2_i, id_use_imm_i, id_imm_i, id_wd_i, id_wreg_i,
           rf_rdata1_i, rf_rdata2_i, ex_wd_i, ex_wreg_i, ex_wdata_i, ex_load_i,
           mem_wd_i, mem_wreg_i, mem_wdata_i, stall_i, flush_i,
    input  id_ready_o, valid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o,
           wreg_o, hazard_cnt_o
  );

  modport slave (
    input  id_valid_i, id_aluop_i, id_alusel_i, id_re1_i, id_re2_i,
           id_raddr1_i, id_raddr2_i, id_use_imm_i, id_imm_i, id_wd_i, id_wreg_i,
           rf_rdata1_i, rf_rdata2_i, ex_wd_i, ex_wreg_i, ex_wdata_i, ex_load_i,
           mem_wd_i, mem_wreg_i, mem_wdata_i, stall_i, flush_i,
    output id_ready_o, valid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o,
           wreg_o, hazard_cnt_o
  );
endinterface

// File: rtl/id_ex_issue.sv
// id_ex_issue: ID/EX issue register. Resolves both source operands (immediate,
// $0, EX forward, MEM forward, register file), detects load-use hazards,
// and registers the ALU fields for the execute stage.
//   clk  : rising-edge clock
//   rst  : async active-low reset
//   bus  : id_ex_issue_if.slave (decode request, forwarding, stall/flush, outputs)

// Per-port operand resolver. Also flags a raw dependency on the EX destination
// for load-use detection (gated with load/valid at the top).
module id_ex_fwd #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               re,
  input  logic [RADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0]  rf,
  input  logic               sel_imm,
  input  logic [DATA_W-1:0]  imm,
  input  logic               ex_wreg,
  input  logic [RADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0]  ex_wdata,
  input  logic               mem_wreg,
  input  logic [RADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]  opnd,
  output logic               ex_dep
);
  always_comb begin
    opnd = '0;
    if (sel_imm)                          opnd = imm;
    else if (!re || raddr == '0)          opnd = '0;
    else if (ex_wreg && ex_wd == raddr)   opnd = ex_wdata;   // youngest producer first
    else if (mem_wreg && mem_wd == raddr) opnd = mem_wdata;
    else                                  opnd = rf;
  end

  assign ex_dep = re && !sel_imm && (raddr == ex_wd);
endmodule

module id_ex_issue #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_issue_if.slave bus
);
  localparam int NPORT = 2;

  logic [NPORT-1:0]              re, sel_imm, ex_dep;
  logic [NPORT-1:0][RADDR_W-1:0] raddr;
  logic [NPORT-1:0][DATA_W-1:0]  rf, imm, opnd;
  logic                          hazard;

  assign re      = {bus.id_re2_i, bus.id_re1_i};
  assign raddr   = {bus.id_raddr2_i, bus.id_raddr1_i};
  assign rf      = {bus.rf_rdata2_i, bus.rf_rdata1_i};
  assign sel_imm = {bus.id_use_imm_i, 1'b0};        // only port 2 takes the immediate
  assign imm     = {bus.id_imm_i, {DATA_W{1'b0}}};

  genvar p;
  generate
    for (p = 0; p < NPORT; p++) begin : g_port
      id_ex_fwd #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd (
        .re(re[p]), .raddr(raddr[p]), .rf(rf[p]),
        .sel_imm(sel_imm[p]), .imm(imm[p]),
        .ex_wreg(bus.ex_wreg_i), .ex_wd(bus.ex_wd_i), .ex_wdata(bus.ex_wdata_i),
        .mem_wreg(bus.mem_wreg_i), .mem_wd(bus.mem_wd_i), .mem_wdata(bus.mem_wdata_i),
        .opnd(opnd[p]), .ex_dep(ex_dep[p])
      );
    end
  endgenerate

  // Load in EX has no data yet: one bubble, then it forwards from MEM.
  assign hazard = bus.id_valid_i && bus.ex_load_i && bus.ex_wreg_i &&
                  (bus.ex_wd_i != '0) && (|ex_dep);

  assign bus.id_ready_o = bus.flush_i || (!bus.stall_i && !hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.valid_o      <= 1'b0;
      bus.aluop_o      <= '0;
      bus.alusel_o     <= '0;
      bus.reg1_o       <= '0;
      bus.reg2_o       <= '0;
      bus.wd_o         <= '0;
      bus.wreg_o       <= 1'b0;
      bus.hazard_cnt_o <= '0;
    end else if (bus.flush_i || (!bus.stall_i && (hazard || !bus.id_valid_i))) begin
      // bubble; stall holds everything so only the hazard path counts
      bus.valid_o  <= 1'b0;
      bus.aluop_o  <= '0;
      bus.alusel_o <= '0;
      bus.reg1_o   <= '0;
      bus.reg2_o   <= '0;
      bus.wd_o     <= '0;
      bus.wreg_o   <= 1'b0;
      if (!bus.flush_i && hazard && bus.hazard_cnt_o != 16'hFFFF)
        bus.hazard_cnt_o <= bus.hazard_cnt_o + 16'd1;
    end else if (!bus.stall_i) begin
      bus.valid_o  <= 1'b1;
      bus.aluop_o  <= bus.id_aluop_i;
      bus.alusel_o <= bus.id_alusel_i;
      bus.reg1_o   <= opnd[0];
      bus.reg2_o   <= opnd[1];
      bus.wd_o     <= bus.id_wd_i;
      bus.wreg_o   <= bus.id_wreg_i;
    end
  end
endmodule

// File: tb/tb_id_ex_issue.sv
module tb_id_ex_issue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_issue_if bus();
  id_ex_issue dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1, r2;
    logic [4:0]  wd;
    bit          wreg;
  } issue_t;

  issue_t m_out;
  int     m_cnt;
  localparam issue_t BUBBLE = '{0, 8'h0, 3'h0, 32'h0, 32'h0, 5'h0, 0};

  // Operand source: newest matching producer (EX, then MEM), else regfile.
  function automatic logic [31:0] m_src(bit re, logic [4:0] a, logic [31:0] rf);
    logic [4:0]  pwd[2];
    bit          pw[2];
    logic [31:0] pdat[2];
    if (!re || a == 0) return 32'h0;
    pwd = '{bus.ex_wd_i, bus.mem_wd_i};
    pw  = '{bus.ex_wreg_i, bus.mem_wreg_i};
    pdat = '{bus.ex_wdata_i, bus.mem_wdata_i};
    for (int i = 0; i < 2; i++) if (pw[i] && pwd[i] == a) return pdat[i];
    return rf;
  endfunction

  function automatic bit m_hazard();
    if (!(bus.id_valid_i && bus.ex_load_i && bus.ex_wreg_i && bus.ex_wd_i != 0)) return 0;
    return (bus.id_re1_i && bus.id_raddr1_i == bus.ex_wd_i) ||
           (bus.id_re2_i && !bus.id_use_imm_i && bus.id_raddr2_i == bus.ex_wd_i);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out <= BUBBLE;
      m_cnt <= 0;
    end else if (bus.flush_i) m_out <= BUBBLE;
    else if (bus.stall_i) ;
    else if (m_hazard()) begin
      m_out <= BUBBLE;
      m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else if (bus.id_valid_i)
      m_out <= '{1, bus.id_aluop_i, bus.id_alusel_i,
                 m_src(bus.id_re1_i, bus.id_raddr1_i, bus.rf_rdata1_i),
                 bus.id_use_imm_i ? bus.id_imm_i
                                  : m_src(bus.id_re2_i, bus.id_raddr2_i, bus.rf_rdata2_i),
                 bus.id_wd_i, bus.id_wreg_i};
    else m_out <= BUBBLE;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("m_valid",  {31'h0, bus.valid_o}, {31'h0, m_out.v});
    chk("m_aluop",  {24'h0, bus.aluop_o}, {24'h0, m_out.aluop});
    chk("m_alusel", {29'h0, bus.alusel_o}, {29'h0, m_out.alusel});
    chk("m_reg1",   bus.reg1_o, m_out.r1);
    chk("m_reg2",   bus.reg2_o, m_out.r2);
    chk("m_wd",     {27'h0, bus.wd_o}, {27'h0, m_out.wd});
    chk("m_wreg",   {31'h0, bus.wreg_o}, {31'h0, m_out.wreg});
    chk("m_cnt",    {16'h0, bus.hazard_cnt_o}, m_cnt);
    chk("m_ready",  {31'h0, bus.id_ready_o},
        {31'h0, bus.flush_i || (!bus.stall_i && !m_hazard())});
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    bus.id_valid_i = 0; bus.id_aluop_i = 0; bus.id_alusel_i = 0;
    bus.id_re1_i = 0; bus.id_re2_i = 0; bus.id_raddr1_i = 0; bus.id_raddr2_i = 0;
    bus.id_use_imm_i = 0; bus.id_imm_i = 0; bus.id_wd_i = 0; bus.id_wreg_i = 0;
    bus.rf_rdata1_i = 0; bus.rf_rdata2_i = 0;
    bus.ex_wd_i = 0; bus.ex_wreg_i = 0; bus.ex_wdata_i = 0; bus.ex_load_i = 0;
    bus.mem_wd_i = 0; bus.mem_wreg_i = 0; bus.mem_wdata_i = 0;
    bus.stall_i = 0; bus.flush_i = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    // reset with random inputs
    repeat (3) begin
      bus.id_valid_i = 1'($urandom); bus.id_re1_i = 1'($urandom); bus.id_re2_i = 1'($urandom);
      bus.id_raddr1_i = 5'($urandom); bus.id_raddr2_i = 5'($urandom);
      bus.id_aluop_i = 8'($urandom); bus.rf_rdata1_i = $urandom; bus.rf_rdata2_i = $urandom;
      bus.ex_wd_i = 5'($urandom); bus.ex_wreg_i = 1'($urandom); bus.ex_load_i = 1'($urandom);
      bus.ex_wdata_i = $urandom; bus.stall_i = 1'($urandom);
      step();
    end
    chk("rst_valid", {31'h0, bus.valid_o}, 0);
    chk("rst_reg1",  bus.reg1_o, 0);
    chk("rst_aluop", {24'h0, bus.aluop_o}, 0);
    chk("rst_cnt",   {16'h0, bus.hazard_cnt_o}, 0);
    idle();
    rst = 1;

    // first capture: add r1=3 r2=4
    bus.id_valid_i = 1; bus.id_aluop_i = 8'h20; bus.id_alusel_i = 3'd1;
    bus.id_re1_i = 1; bus.id_re2_i = 1; bus.id_raddr1_i = 3; bus.id_raddr2_i = 4;
    bus.rf_rdata1_i = 32'h11; bus.rf_rdata2_i = 32'h22; bus.id_wd_i = 2; bus.id_wreg_i = 1;
    step();
    chk("first_valid", {31'h0, bus.valid_o}, 1);
    chk("first_reg1", bus.reg1_o, 32'h11);
    chk("first_reg2", bus.reg2_o, 32'h22);
    chk("first_aluop", {24'h0, bus.aluop_o}, 32'h20);

    // forwarding priority (back-to-back issue)
    bus.id_raddr1_i = 5; bus.rf_rdata1_i = 32'h999;
    bus.ex_wreg_i = 1; bus.ex_wd_i = 5; bus.ex_wdata_i = 32'hAAAA;
    bus.mem_wreg_i = 1; bus.mem_wd_i = 5; bus.mem_wdata_i = 32'hBBBB;
    step();
    chk("fwd_ex", bus.reg1_o, 32'hAAAA);
    bus.ex_wreg_i = 0;
    step();
    chk("fwd_mem", bus.reg1_o, 32'hBBBB);

    // $0 and immediate
    idle();
    bus.id_valid_i = 1; bus.id_re1_i = 1; bus.id_raddr1_i = 0; bus.rf_rdata1_i = 32'h5;
    bus.ex_wreg_i = 1; bus.ex_wd_i = 0; bus.ex_wdata_i = 32'hFFFF;
    bus.id_use_imm_i = 1; bus.id_imm_i = 32'h1234; bus.id_re2_i = 0;
    step();
    chk("zero_reg1", bus.reg1_o, 0);
    chk("imm_reg2", bus.reg2_o, 32'h1234);

    // load-use: one bubble, then MEM forward
    idle();
    bus.id_valid_i = 1; bus.id_re2_i = 1; bus.id_raddr2_i = 7; bus.rf_rdata2_i = 32'h3;
    bus.ex_load_i = 1; bus.ex_wreg_i = 1; bus.ex_wd_i = 7;
    #1 chk("lu_ready", {31'h0, bus.id_ready_o}, 0);
    step();
    chk("lu_bubble", {31'h0, bus.valid_o}, 0);
    chk("lu_cnt", {16'h0, bus.hazard_cnt_o}, 1);
    bus.ex_load_i = 0; bus.ex_wreg_i = 0;
    bus.mem_wreg_i = 1; bus.mem_wd_i = 7; bus.mem_wdata_i = 32'h55;
    step();
    chk("lu_reg2", bus.reg2_o, 32'h55);
    chk("lu_valid", {31'h0, bus.valid_o}, 1);

    // stall freezes, flush overrides stall
    idle();
    bus.id_valid_i = 1; bus.id_re1_i = 1; bus.id_raddr1_i = 6; bus.rf_rdata1_i = 32'h77;
    bus.id_aluop_i = 8'h21; bus.id_wd_i = 6; bus.id_wreg_i = 1;
    step();
    chk("st_cap", bus.reg1_o, 32'h77);
    bus.stall_i = 1; bus.rf_rdata1_i = 32'h88;
    bus.ex_wreg_i = 1; bus.ex_wd_i = 6; bus.ex_wdata_i = 32'h99;
    repeat (3) begin
      #1 chk("st_ready", {31'h0, bus.id_ready_o}, 0);
      step();
      chk("st_hold", bus.reg1_o, 32'h77);
    end
    bus.flush_i = 1;
    #1 chk("fl_ready", {31'h0, bus.id_ready_o}, 1);
    step();
    chk("fl_valid", {31'h0, bus.valid_o}, 0);
    chk("fl_reg1", bus.reg1_o, 0);

    // flush with hazard: no count
    idle();
    bus.id_valid_i = 1; bus.id_re1_i = 1; bus.id_raddr1_i = 3;
    bus.ex_load_i = 1; bus.ex_wreg_i = 1; bus.ex_wd_i = 3; bus.flush_i = 1;
    step();
    chk("flhz_cnt", {16'h0, bus.hazard_cnt_o}, 1);

    // saturation
    bus.flush_i = 0;
    repeat (65540) @(posedge clk);
    #1 chk("sat_cnt", {16'h0, bus.hazard_cnt_o}, 32'hFFFF);
    idle();
    step();
    chk("sat_hold", {16'h0, bus.hazard_cnt_o}, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
